// File: rtl/l1_cache_if.sv
// Request/response bus shared by the CPU->L1 and L1->L2 links.
// The requester drives address, write data and strobes; the responder returns data, ready and hit.
interface l1_cache_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  read;
  logic                  write;
  logic                  ready;
  logic                  hit;

  modport master (
    output addr, wdata, read, write,
    input  rdata, ready, hit
  );

  modport slave (
    input  addr, wdata, read, write,
    output rdata, ready, hit
  );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, one-word-per-line L1 cache: write-through, no-write-allocate,
// blocking single outstanding request to L2, saturating hit/miss counters.
module l1_cache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_LINES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  l1_cache_if.slave   cpu,
  l1_cache_if.master  l2,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned BLK_W   = ADDR_WIDTH - 2;
  localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W - 2;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLookup  = 2'd1;
  localparam logic [1:0] StL2Read  = 2'd2;
  localparam logic [1:0] StL2Write = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [BLK_W-1:0]      blk_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  lookup_hit_q;

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q, hit_q;
  logic                  l2_read_q, l2_write_q;
  logic [ADDR_WIDTH-1:0] l2_addr_q;
  logic [DATA_WIDTH-1:0] l2_wdata_q;
  logic [15:0]           hit_count_q, miss_count_q;

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  req;
  logic [ADDR_WIDTH-1:0] line_addr;

  assign idx       = blk_q[INDEX_W-1:0];
  assign tag       = blk_q[BLK_W-1:INDEX_W];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign line_addr = {blk_q, 2'b00};
  // A new request is not accepted in the cycle the previous one is being acknowledged.
  assign req       = (cpu.read | cpu.write) & ~ready_q;

  // Byte offset and L2 hit status carry no information this cache acts on.
  logic unused_in;
  assign unused_in = ^{cpu.addr[1:0], l2.hit};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req) state_d = StLookup;
      StLookup:  state_d = write_q ? StL2Write : (hit ? StIdle : StL2Read);
      StL2Read:  if (l2.ready) state_d = StIdle;
      StL2Write: if (l2.ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      blk_q        <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      lookup_hit_q <= 1'b0;
      valid_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      hit_q        <= 1'b0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            blk_q   <= cpu.addr[ADDR_WIDTH-1:2];
            wdata_q <= cpu.wdata;
            write_q <= cpu.write;
          end
        end
        StLookup: begin
          lookup_hit_q <= hit;
          if (hit) begin
            if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
          end else begin
            if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
          end
          if (write_q) begin
            l2_write_q <= 1'b1;
            l2_addr_q  <= line_addr;
            l2_wdata_q <= wdata_q;
          end else if (hit) begin
            rdata_q <= data_q[idx];
            ready_q <= 1'b1;
            hit_q   <= 1'b1;
          end else begin
            l2_read_q <= 1'b1;
            l2_addr_q <= line_addr;
          end
        end
        StL2Read: begin
          if (l2.ready) begin
            valid_q[idx] <= 1'b1;
            rdata_q      <= l2.rdata;
            ready_q      <= 1'b1;
            l2_read_q    <= 1'b0;
          end
        end
        StL2Write: begin
          if (l2.ready) begin
            l2_write_q <= 1'b0;
            ready_q    <= 1'b1;
            hit_q      <= lookup_hit_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (state_q == StL2Read && l2.ready) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= l2.rdata;
    end else if (state_q == StLookup && write_q && hit) begin
      data_q[idx] <= wdata_q;
    end
  end

  assign cpu.rdata  = rdata_q;
  assign cpu.ready  = ready_q;
  assign cpu.hit    = hit_q;
  assign l2.read    = l2_read_q;
  assign l2.write   = l2_write_q;
  assign l2.addr    = l2_addr_q;
  assign l2.wdata   = l2_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_l1_cache.sv
// Scoreboard bench for l1_cache: directed requests push expected CPU and L2 transactions,
// independent monitors pop and compare; a small L2 model answers with programmable latency.
module tb_l1_cache;

  logic        clk;
  logic        rst_n;
  logic [15:0] hit_count, miss_count;

  l1_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) cpu_if ();
  l1_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) l2_if ();

  l1_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_LINES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (cpu_if),
    .l2         (l2_if),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic hit; } cpu_exp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } l2_exp_t;

  cpu_exp_t cpu_q[$];
  l2_exp_t  l2_q[$];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 32'h0;
  logic [15:0] exp_hits = 16'h0;
  logic [15:0] exp_misses = 16'h0;

  // L2 model controls
  logic [31:0] l2_rdata_v = 32'h0;
  int          l2_lat = 1;
  int          l2_rd_cycles = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // L2 responder: ready rises in the l2_lat-th cycle of a held request, for one cycle.
  initial begin
    int cnt;
    cnt = 0;
    l2_if.ready = 1'b0;
    l2_if.rdata = 32'h0;
    l2_if.hit   = 1'b0;
    forever begin
      @(negedge clk);
      if (l2_if.read) l2_rd_cycles++;
      if (l2_if.ready) begin
        l2_if.ready = 1'b0;
        cnt = 0;
      end else if (l2_if.read || l2_if.write) begin
        cnt++;
        if (cnt >= l2_lat) begin
          l2_if.ready = 1'b1;
          l2_if.rdata = l2_rdata_v;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // CPU-side monitor
  cpu_exp_t ce;
  always @(negedge clk) begin
    if (cpu_if.ready) begin
      if (cpu_q.size() == 0) begin
        chk("cpu_unexpected_ready", 32'h1, 32'h0);
      end else begin
        ce = cpu_q.pop_front();
        chk("cpu_data_out", cpu_if.rdata, ce.data);
        chk("cpu_hit", 32'(cpu_if.hit), 32'(ce.hit));
      end
    end
  end

  // L2-side monitor: one comparison set per new request
  l2_exp_t le;
  logic    l2_prev = 1'b0;
  always @(negedge clk) begin
    if ((l2_if.read || l2_if.write) && !l2_prev) begin
      chk("l2_rd_wr_exclusive", 32'(l2_if.read && l2_if.write), 32'h0);
      if (l2_q.size() == 0) begin
        chk("l2_unexpected_req", 32'h1, 32'h0);
      end else begin
        le = l2_q.pop_front();
        chk("l2_addr", l2_if.addr, le.addr);
        chk("l2_write", 32'(l2_if.write), 32'(le.wr));
        chk("l2_read", 32'(l2_if.read), 32'(!le.wr));
        if (le.wr) chk("l2_data_out", l2_if.wdata, le.wdata);
      end
    end
    l2_prev = l2_if.read || l2_if.write;
  end

  // rdata: expected read result (and L2 return data on a read miss); ignored for writes.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_hit, input logic [31:0] rdata, input int lat);
    cpu_exp_t e;
    l2_exp_t  r;
    int       n;
    e.data = wr ? last_rd : rdata;
    e.hit  = exp_hit;
    cpu_q.push_back(e);
    if (wr || !exp_hit) begin
      r.addr  = a & ~32'h3;
      r.wr    = wr;
      r.wdata = d;
      l2_q.push_back(r);
    end
    l2_rdata_v   = rdata;
    l2_lat       = lat;
    l2_rd_cycles = 0;
    @(negedge clk);
    cpu_if.read  = rd;
    cpu_if.write = wr;
    cpu_if.addr  = a;
    cpu_if.wdata = d;
    @(negedge clk);
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
    n = 1;
    while (!cpu_if.ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_if.ready) chk("cpu_ready_timeout", 32'h0, 32'h1);
    if (!wr) last_rd = rdata;
    if (exp_hit) exp_hits = (exp_hits == 16'hFFFF) ? 16'hFFFF : exp_hits + 16'd1;
    else         exp_misses = (exp_misses == 16'hFFFF) ? 16'hFFFF : exp_misses + 16'd1;
    if (rd && !wr && exp_hit)  chk("read_hit_latency", 32'(n), 32'd2);
    if (rd && !wr && !exp_hit) chk("l2_read_held_cycles", 32'(l2_rd_cycles), 32'(lat));
    if (!(rd && !wr && !exp_hit)) chk("l2_read_absent", 32'(l2_rd_cycles), 32'h0);
    @(negedge clk);
    chk("hit_count", 32'(hit_count), 32'(exp_hits));
    chk("miss_count", 32'(miss_count), 32'(exp_misses));
  endtask

  initial begin
    l2_exp_t r;
    rst_n        = 1'b0;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
    cpu_if.addr  = 32'h0;
    cpu_if.wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_if.ready), 32'h0);
    chk("rst_cpu_hit", 32'(cpu_if.hit), 32'h0);
    chk("rst_cpu_data_out", cpu_if.rdata, 32'h0);
    chk("rst_l2_req", 32'({l2_if.read, l2_if.write}), 32'h0);
    chk("rst_l2_addr", l2_if.addr, 32'h0);
    chk("rst_l2_data_out", l2_if.wdata, 32'h0);
    chk("rst_counts", {hit_count, miss_count}, 32'h0);
    rst_n = 1'b1;

    //   rd    wr    addr          wdata         hit   rdata         lat
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'hDEADBEEF, 3);
    txn(1'b1, 1'b0, 32'h0000_0102, 32'h0,        1'b1, 32'hDEADBEEF, 1);
    txn(1'b0, 1'b1, 32'h0000_0100, 32'h12345678, 1'b1, 32'h0,        2);
    txn(1'b0, 1'b1, 32'h0000_0200, 32'h00000001, 1'b0, 32'h0,        1);
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0,        1'b1, 32'h12345678, 1);
    txn(1'b1, 1'b0, 32'h0000_0200, 32'h0,        1'b0, 32'hA5A50200, 1);
    // Same-index conflict: 0x100 and 0x200 both map to line 0
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h11110100, 5);
    txn(1'b1, 1'b0, 32'h0000_0200, 32'h0,        1'b0, 32'h22220200, 2);
    txn(1'b1, 1'b0, 32'h0000_0200, 32'h0,        1'b1, 32'h22220200, 1);
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h33330100, 1);
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0,        1'b0, 32'h44440104, 2);
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0,        1'b1, 32'h33330100, 1);
    // Simultaneous read+write behaves as a write
    txn(1'b1, 1'b1, 32'h0000_0107, 32'hCAFEF00D, 1'b1, 32'h0,        2);
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0,        1'b1, 32'hCAFEF00D, 1);

    // Reset while a read miss waits on L2
    r.addr = 32'h0000_0300; r.wr = 1'b0; r.wdata = 32'h0;
    l2_q.push_back(r);
    l2_lat = 20;
    @(negedge clk);
    cpu_if.read = 1'b1;
    cpu_if.addr = 32'h0000_0300;
    @(negedge clk);
    cpu_if.read = 1'b0;
    repeat (3) @(negedge clk);
    chk("l2_read_before_rst", 32'(l2_if.read), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("l2_read_async_drop", 32'(l2_if.read), 32'h0);
    chk("cpu_ready_in_rst", 32'(cpu_if.ready), 32'h0);
    chk("cpu_data_out_in_rst", cpu_if.rdata, 32'h0);
    chk("counts_in_rst", {hit_count, miss_count}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    last_rd    = 32'h0;
    exp_hits   = 16'h0;
    exp_misses = 16'h0;
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0,        1'b0, 32'h55550104, 3);

    // Counter saturation
    @(negedge clk);
    force dut.hit_count_q = 16'hFFFE;
    #1 release dut.hit_count_q;
    exp_hits = 16'hFFFE;
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0,        1'b1, 32'h55550104, 1);
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0,        1'b1, 32'h55550104, 1);
    @(negedge clk);
    force dut.miss_count_q = 16'hFFFF;
    #1 release dut.miss_count_q;
    exp_misses = 16'hFFFF;
    txn(1'b1, 1'b0, 32'h0000_0500, 32'h0,        1'b0, 32'h66660500, 1);

    repeat (3) @(negedge clk);
    chk("cpu_scoreboard_drained", 32'(cpu_q.size()), 32'h0);
    chk("l2_scoreboard_drained", 32'(l2_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
